// File: rtl/mse_run_controller.sv
// Host-side run sequencer for the squared-error accumulator.
// For each batch it pulses acc_start and waits for the accumulator's result pulse.
// It then streams the captured result to the host LSB byte first over valid/ready.
// It repeats for the commanded number of batches.
// It flags a result wait that runs too long, and result pulses that arrive when none is expected.
//
// state   | meaning
// S_IDLE  | ready for a host command
// S_START | launch one accumulator run
// S_WAIT  | waiting for the result pulse, timer running
// S_SEND  | streaming captured result bytes to the host
module mse_run_controller #(
    parameter int          RES_WL   = 64,
    parameter int          RUN_WL   = 16,
    parameter int          TIMER_WL = 32,
    parameter int unsigned TIMEOUT  = 131088
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [RUN_WL-1:0] cmd_runs,
    output logic              acc_start,
    input  logic              res_valid,
    input  logic [RES_WL-1:0] res_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_last,
    output logic              busy,
    output logic [RUN_WL-1:0] run_idx,
    output logic              done,
    output logic              err_timeout,
    output logic              err_spurious
);

    localparam int NB    = RES_WL / 8;
    localparam int BC_WL = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BC_WL-1:0]    BYTE_LAST = BC_WL'(NB - 1);
    localparam logic [TIMER_WL-1:0] TO_LAST   = TIMER_WL'(TIMEOUT - 1);

    // One-hot so that every state decode below is a single flop output.
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_START = 4'b0010,
        S_WAIT  = 4'b0100,
        S_SEND  = 4'b1000
    } state_t;

    state_t              state_q, state_d;
    logic [RUN_WL-1:0]   runs_left_q, runs_left_d;
    logic [RUN_WL-1:0]   run_idx_q, run_idx_d;
    logic [TIMER_WL-1:0] timer_q, timer_d;
    logic [RES_WL-1:0]   shift_q, shift_d;
    logic [BC_WL-1:0]    byte_cnt_q, byte_cnt_d;
    logic                acc_start_q, acc_start_d;
    logic                done_q, done_d;
    logic                err_timeout_q, err_timeout_d;
    logic                err_spurious_q, err_spurious_d;

    // Register all state; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= S_IDLE;
            runs_left_q    <= '0;
            run_idx_q      <= '0;
            timer_q        <= '0;
            shift_q        <= '0;
            byte_cnt_q     <= '0;
            acc_start_q    <= 1'b0;
            done_q         <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            runs_left_q    <= runs_left_d;
            run_idx_q      <= run_idx_d;
            timer_q        <= timer_d;
            shift_q        <= shift_d;
            byte_cnt_q     <= byte_cnt_d;
            acc_start_q    <= acc_start_d;
            done_q         <= done_d;
            err_timeout_q  <= err_timeout_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    // Next-state and datapath updates; pulses default low and everything else holds.
    always_comb begin
        state_d        = state_q;
        runs_left_d    = runs_left_q;
        run_idx_d      = run_idx_q;
        timer_d        = timer_q;
        shift_d        = shift_q;
        byte_cnt_d     = byte_cnt_q;
        acc_start_d    = 1'b0;
        done_d         = 1'b0;
        err_timeout_d  = err_timeout_q;
        err_spurious_d = err_spurious_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    err_timeout_d  = 1'b0;
                    err_spurious_d = 1'b0;
                    run_idx_d      = '0;
                    if (cmd_runs == '0) begin
                        done_d = 1'b1;
                    end else begin
                        runs_left_d = cmd_runs;
                        state_d     = S_START;
                    end
                end
            end
            S_START: begin
                // The start flop fires on the first WAIT cycle, aligned with timer == 0.
                acc_start_d = 1'b1;
                timer_d     = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + TIMER_WL'(1);
                if (res_valid) begin
                    shift_d    = res_data;
                    byte_cnt_d = '0;
                    state_d    = S_SEND;
                end else if (timer_q == TO_LAST) begin
                    err_timeout_d = 1'b1;
                    done_d        = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_SEND: begin
                if (tx_ready) begin
                    shift_d    = shift_q >> 8;
                    byte_cnt_d = byte_cnt_q + BC_WL'(1);
                    if (byte_cnt_q == BYTE_LAST) begin
                        if (runs_left_q == RUN_WL'(1)) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            runs_left_d = runs_left_q - RUN_WL'(1);
                            run_idx_d   = run_idx_q + RUN_WL'(1);
                            state_d     = S_START;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A result pulse outside WAIT is only flagged; the captured data is left alone.
        // This comes after the command's flag clear, so a pulse coinciding with a command still counts.
        if (res_valid && (state_q != S_WAIT)) begin
            err_spurious_d = 1'b1;
        end
    end

    assign cmd_ready    = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign tx_valid     = (state_q == S_SEND);
    assign tx_last      = (state_q == S_SEND) && (byte_cnt_q == BYTE_LAST);
    assign tx_data      = shift_q[7:0];
    assign acc_start    = acc_start_q;
    assign done         = done_q;
    assign run_idx      = run_idx_q;
    assign err_timeout  = err_timeout_q;
    assign err_spurious = err_spurious_q;

endmodule

// File: tb/tb_mse_run_controller.sv
// Directed bench for mse_run_controller.
// A small timeout keeps the waits short.
// Result bytes go into a scoreboard queue when the result pulse is driven.
// A negedge monitor pops the queue on every accepted byte.
module tb_mse_run_controller;

    localparam int TIMEOUT = 100;
    localparam int SEQ_LEN = 37;
    localparam int RES_DLY = SEQ_LEN + 3;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_runs = '0;
    logic        acc_start;
    logic        res_valid = 1'b0;
    logic [63:0] res_data = '0;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_last;
    logic        busy;
    logic [15:0] run_idx;
    logic        done;
    logic        err_timeout;
    logic        err_spurious;

    int errors = 0;
    int checks = 0;

    // entry = {done expected after this byte, tx_last, byte}
    logic [9:0] exp_q[$];
    int n_acc = 0, n_done = 0, n_tx = 0;
    int rdy_mode = 0, rdy_ph = 0;
    bit prev_stall = 0, exp_done = 0, prev_acc = 0;
    logic [7:0] stall_data;
    logic       stall_last;

    mse_run_controller #(
        .RES_WL(64), .RUN_WL(16), .TIMER_WL(32), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_runs(cmd_runs),
        .acc_start(acc_start), .res_valid(res_valid), .res_data(res_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
        .busy(busy), .run_idx(run_idx), .done(done),
        .err_timeout(err_timeout), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [15:0] runs);
        cmd_runs  = runs;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_acc();
        int n = 0;
        while (acc_start !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("acc_start_seen", 64'(acc_start), 64'd1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("done_seen", 64'(done), 64'd1);
    endtask

    task automatic deliver(input logic [63:0] val, input int dly, input bit fin);
        repeat (dly) tick();
        for (int i = 0; i < 8; i++)
            exp_q.push_back({fin && (i == 7), (i == 7), val[8*i +: 8]});
        res_valid = 1'b1;
        res_data  = val;
        tick();
        res_valid = 1'b0;
        res_data  = 64'hFFFF_0000_FFFF_0000;
        chk("tx_valid_latency", 64'(tx_valid), 64'd1);
    endtask

    // Host side: drive tx_ready, pop the scoreboard on accepted bytes, check stall stability.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 0;
            exp_done   = 0;
            prev_acc   = 0;
        end else begin
            if (exp_done) begin
                chk("done_after_last", 64'(done), 64'd1);
                chk("idle_after_done", 64'(busy), 64'd0);
                exp_done = 0;
            end
            if (acc_start === 1'b1) begin
                chk("acc_start_one_cycle", 64'(prev_acc), 64'd0);
                n_acc++;
            end
            prev_acc = acc_start;
            if (done === 1'b1) n_done++;
            if (prev_stall) begin
                chk("stall_valid", 64'(tx_valid), 64'd1);
                chk("stall_data", 64'(tx_data), 64'(stall_data));
                chk("stall_last", 64'(tx_last), 64'(stall_last));
            end
            if (rdy_mode == 1) begin
                tx_ready = (rdy_ph == 0);
                rdy_ph   = (rdy_ph == 2) ? 0 : rdy_ph + 1;
            end else begin
                tx_ready = 1'b1;
            end
            if (tx_valid === 1'b1 && tx_ready) begin
                chk("sb_has_entry", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    chk("tx_data", 64'(tx_data), 64'(e[7:0]));
                    chk("tx_last", 64'(tx_last), 64'(e[8]));
                    exp_done = e[9];
                end
                n_tx++;
                prev_stall = 0;
            end else if (tx_valid === 1'b1) begin
                prev_stall = 1;
                stall_data = tx_data;
                stall_last = tx_last;
            end else begin
                prev_stall = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, b_acc, b_done, b_tx;

        // reset state
        rstn = 1'b0;
        tick();
        tick();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_acc_start", 64'(acc_start), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        rstn = 1'b1;
        tick();

        // 1: one batch, host always ready
        b_tx = n_tx;
        send_cmd(16'd1);
        chk("t1_start_lat_1", 64'(acc_start), 64'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_cmd_ready", 64'(cmd_ready), 64'd0);
        tick();
        chk("t1_start_lat_2", 64'(acc_start), 64'd1);
        chk("t1_run_idx", 64'(run_idx), 64'd0);
        deliver(64'h0123_4567_89AB_CDEF, RES_DLY - 1, 1'b1);
        wait_done(n);
        tick();
        chk("t1_bytes", 64'(n_tx - b_tx), 64'd8);
        chk("t1_busy_end", 64'(busy), 64'd0);

        // 2: same with host stalling 1,0,0,...
        rdy_mode = 1;
        rdy_ph   = 0;
        b_tx     = n_tx;
        send_cmd(16'd1);
        wait_acc();
        deliver(64'h0123_4567_89AB_CDEF, RES_DLY - 1, 1'b1);
        wait_done(n);
        tick();
        chk("t2_bytes", 64'(n_tx - b_tx), 64'd8);
        rdy_mode = 0;

        // 3: three batches
        b_acc  = n_acc;
        b_done = n_done;
        b_tx   = n_tx;
        send_cmd(16'd3);
        for (int r = 0; r < 3; r++) begin
            wait_acc();
            chk("t3_run_idx", 64'(run_idx), 64'(r));
            chk("t3_start_after_last_byte", 64'(exp_q.size()), 64'd0);
            deliver(64'(r + 1), 10, r == 2);
        end
        wait_done(n);
        tick();
        chk("t3_acc_count", 64'(n_acc - b_acc), 64'd3);
        chk("t3_done_count", 64'(n_done - b_done), 64'd1);
        chk("t3_bytes", 64'(n_tx - b_tx), 64'd24);

        // result on the last permitted wait cycle beats the timeout
        send_cmd(16'd1);
        wait_acc();
        deliver(64'hFEDC_BA98_7654_3210, TIMEOUT - 1, 1'b1);
        wait_done(n);
        chk("edge_no_timeout", 64'(err_timeout), 64'd0);
        chk("edge_no_spurious", 64'(err_spurious), 64'd0);

        // 4: timeout with no result
        b_tx = n_tx;
        send_cmd(16'd1);
        wait_acc();
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("t4_timeout_cycles", 64'(n), 64'(TIMEOUT));
        chk("t4_err_timeout", 64'(err_timeout), 64'd1);
        chk("t4_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("t4_no_tx", 64'(n_tx - b_tx), 64'd0);

        // 5: spurious result in IDLE, then an empty command
        res_valid = 1'b1;
        res_data  = 64'h1111_2222_3333_4444;
        tick();
        res_valid = 1'b0;
        chk("t5_err_spurious", 64'(err_spurious), 64'd1);
        chk("t5_tx_valid", 64'(tx_valid), 64'd0);
        repeat (3) tick();
        chk("t5_no_tx", 64'(n_tx - b_tx), 64'd0);
        b_acc = n_acc;
        send_cmd(16'd0);
        chk("t5_done", 64'(done), 64'd1);
        chk("t5_err_timeout_clr", 64'(err_timeout), 64'd0);
        chk("t5_err_spurious_clr", 64'(err_spurious), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        repeat (5) tick();
        chk("t5_no_acc_start", 64'(n_acc - b_acc), 64'd0);

        // 6: reset in the middle of sending byte 4
        b_tx = n_tx;
        send_cmd(16'd1);
        wait_acc();
        deliver(64'h8877_6655_4433_2211, RES_DLY - 1, 1'b1);
        n = 0;
        while ((n_tx - b_tx) < 4 && n < 50) begin
            tick();
            n++;
        end
        chk("t6_four_bytes", 64'(n_tx - b_tx), 64'd4);
        rstn = 1'b0;
        exp_q.delete();
        tick();
        rstn = 1'b1;
        chk("t6_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_tx_valid", 64'(tx_valid), 64'd0);
        chk("t6_tx_last", 64'(tx_last), 64'd0);
        chk("t6_tx_data", 64'(tx_data), 64'd0);
        chk("t6_done", 64'(done), 64'd0);
        chk("t6_run_idx", 64'(run_idx), 64'd0);
        b_tx  = n_tx;
        b_acc = n_acc;
        repeat (20) tick();
        chk("t6_no_more_tx", 64'(n_tx - b_tx), 64'd0);
        chk("t6_no_acc_start", 64'(n_acc - b_acc), 64'd0);
        send_cmd(16'd1);
        wait_acc();
        deliver(64'hA5A5_5A5A_C3C3_3C3C, RES_DLY - 1, 1'b1);
        wait_done(n);
        tick();
        chk("t6_rerun_bytes", 64'(n_tx - b_tx), 64'd8);

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
